// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two-requester round-robin front end for an APB master.
// Accepts one transaction at a time, sequences the APB master through
// transfer/addresses/data, and returns completion data and status to the
// requester that was served.
//
// Handshake: reqx is a level request and is sampled only in ARB. The winner
// sees gntx=1 from REQ through RESP. Its transaction is complete in the single
// cycle where donex=1, and rdata/err are valid only in that cycle. Request
// inputs are ignored from the grant until the next ARB cycle, so a requester
// may drop or change them freely once granted.
module apb_req_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             req0,
    input  logic             req1,
    input  logic             wr0,
    input  logic             wr1,
    input  logic [WIDTH:0]   addr0,
    input  logic [WIDTH:0]   addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] rdata,
    output logic             err,
    output logic             transfer,
    output logic             read_write,
    output logic [WIDTH:0]   write_paddr,
    output logic [WIDTH:0]   read_paddr,
    output logic [WIDTH-1:0] write_data,
    input  logic             PENABLE,
    input  logic             PREADY,
    input  logic             PSLVERR,
    input  logic [WIDTH-1:0] read_data_out,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_ARB  = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Last WAIT cycle index before the transaction is declared timed out.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_gnt, w_gnt_nxt;
    logic [1:0]       r_done, w_done_nxt;
    logic             r_transfer, w_transfer_nxt;
    logic             r_rw, w_rw_nxt;
    logic [WIDTH:0]   r_addr, w_addr_nxt;
    logic [WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic [WIDTH-1:0] r_rdata, w_rdata_nxt;
    logic             r_err, w_err_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic             r_last, w_last_nxt;   // requester served most recently
    logic             w_pick1;
    logic             w_complete;
    logic             w_abort;
    logic             w_timeout;

    // Next-state and next-output logic; every output is a registered copy.
    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_done_nxt     = 2'b00;
        w_transfer_nxt = 1'b0;
        w_rw_nxt       = r_rw;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_rdata_nxt    = r_rdata;
        w_err_nxt      = r_err;
        w_cnt_nxt      = r_cnt;
        w_last_nxt     = r_last;
        // On a tie the requester that was not served last wins.
        w_pick1        = req1 & (~req0 | ~r_last);
        w_complete     = PENABLE & PREADY;
        w_abort        = PSLVERR & ~PREADY;
        w_timeout      = (r_cnt == CNT_LAST);

        case (r_state)
            S_ARB: begin
                w_gnt_nxt   = 2'b00;
                w_rw_nxt    = 1'b0;
                w_addr_nxt  = '0;
                w_wdata_nxt = '0;
                w_rdata_nxt = '0;
                w_err_nxt   = 1'b0;
                if (req0 | req1) begin
                    w_gnt_nxt      = w_pick1 ? 2'b10 : 2'b01;
                    w_rw_nxt       = w_pick1 ? wr1 : wr0;
                    w_addr_nxt     = w_pick1 ? addr1 : addr0;
                    w_wdata_nxt    = w_pick1 ? wdata1 : wdata0;
                    w_transfer_nxt = 1'b1;
                    w_state_nxt    = S_REQ;
                end
            end
            S_REQ: begin
                w_cnt_nxt   = 8'd0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Completion outranks abort and timeout in the same cycle.
                if (w_complete) begin
                    w_rdata_nxt = r_rw ? '0 : read_data_out;
                    w_err_nxt   = PSLVERR;
                    w_done_nxt  = r_gnt;
                    w_state_nxt = S_RESP;
                end else if (w_abort || w_timeout) begin
                    w_rdata_nxt = '0;
                    w_err_nxt   = 1'b1;
                    w_done_nxt  = r_gnt;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_RESP: begin
                w_last_nxt  = r_gnt[1];
                w_gnt_nxt   = 2'b00;
                w_rw_nxt    = 1'b0;
                w_addr_nxt  = '0;
                w_wdata_nxt = '0;
                w_rdata_nxt = '0;
                w_err_nxt   = 1'b0;
                w_state_nxt = S_ARB;
            end
            default: begin
                w_state_nxt = S_ARB;
            end
        endcase
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs, latched request fields, wait counter and RR pointer.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_gnt      <= 2'b00;
            r_done     <= 2'b00;
            r_transfer <= 1'b0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_cnt      <= 8'd0;
            r_last     <= 1'b1;
        end else begin
            r_gnt      <= w_gnt_nxt;
            r_done     <= w_done_nxt;
            r_transfer <= w_transfer_nxt;
            r_rw       <= w_rw_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_rdata    <= w_rdata_nxt;
            r_err      <= w_err_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last     <= w_last_nxt;
        end
    end

    assign gnt0        = r_gnt[0];
    assign gnt1        = r_gnt[1];
    assign done0       = r_done[0];
    assign done1       = r_done[1];
    assign rdata       = r_rdata;
    assign err         = r_err;
    assign transfer    = r_transfer;
    assign read_write  = r_rw;
    assign write_paddr = r_addr;
    assign read_paddr  = r_addr;
    assign write_data  = r_wdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: transaction-level bench for apb_req_arbiter.
// A small model predicts the winner, completion status and the number of
// WAIT cycles from the arbitration and slave-response rules; an expected
// queue holds the predicted completion for each transaction.
module tb_apb_req_arbiter;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;

  logic             PCLK = 1'b0;
  logic             PRESETn;
  logic             req0, req1, wr0, wr1;
  logic [WIDTH:0]   addr0, addr1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             gnt0, gnt1, done0, done1;
  logic [WIDTH-1:0] rdata;
  logic             err, transfer, read_write;
  logic [WIDTH:0]   write_paddr, read_paddr;
  logic [WIDTH-1:0] write_data;
  logic             PENABLE, PREADY, PSLVERR;
  logic [WIDTH-1:0] read_data_out;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic m_last;                  // model: requester served most recently
  logic [WIDTH+1:0] exp_q[$];    // {who, err, rdata} per predicted completion

  apb_req_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .err(err), .transfer(transfer), .read_write(read_write),
    .write_paddr(write_paddr), .read_paddr(read_paddr), .write_data(write_data),
    .PENABLE(PENABLE), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .read_data_out(read_data_out), .o_dbg_state(dbg_state)
  );

  // clock
  always #5 PCLK = ~PCLK;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_gnt"}, 64'({gnt1, gnt0}), 64'(0));
    check_val({tag, "_done"}, 64'({done1, done0}), 64'(0));
    check_val({tag, "_transfer"}, 64'(transfer), 64'(0));
    check_val({tag, "_rw"}, 64'(read_write), 64'(0));
    check_val({tag, "_wpaddr"}, 64'(write_paddr), 64'(0));
    check_val({tag, "_rpaddr"}, 64'(read_paddr), 64'(0));
    check_val({tag, "_wdata"}, 64'(write_data), 64'(0));
    check_val({tag, "_rdata"}, 64'(rdata), 64'(0));
    check_val({tag, "_err"}, 64'(err), 64'(0));
  endtask

  function automatic logic [WIDTH:0] rnd_addr();
    return {1'($urandom_range(0, 1)), 32'($urandom)};
  endfunction

  task automatic slave_idle();
    PENABLE = 1'b0;
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    read_data_out = $urandom;
  endtask

  // Slave/master behaviour for WAIT cycle i: cycle 0 is Setup, then Access.
  task automatic drive_slave(input int i, input int ready_at, input int abort_at,
                             input logic slverr, input logic [WIDTH-1:0] rd_val);
    PENABLE = (i >= 1);
    PREADY = (i == ready_at) ? 1'b1 : ((i == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    PSLVERR = (i == abort_at) || ((i == ready_at) && slverr);
    read_data_out = (i == ready_at) ? rd_val : $urandom;
  endtask

  // Runs one transaction starting at a negedge in ARB; ends at the negedge of
  // the following ARB cycle.
  task automatic run_txn(input logic r0, input logic r1, input logic w0, input logic w1,
                         input logic [WIDTH:0] a0, input logic [WIDTH:0] a1,
                         input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                         input logic [WIDTH-1:0] rd_val, input int ready_at,
                         input int abort_at, input logic slverr, input string tag);
    logic who, e_wr, e_err;
    logic [WIDTH:0] e_addr;
    logic [WIDTH-1:0] e_wdata, e_rdata;
    logic [WIDTH+1:0] rec;
    int end_i;
    // model: round robin winner and outcome of the slave response plan
    who = (r0 && r1) ? ~m_last : r1;
    e_wr = who ? w1 : w0;
    e_addr = who ? a1 : a0;
    e_wdata = who ? d1 : d0;
    end_i = TIMEOUT - 1;
    e_err = 1'b1;
    e_rdata = '0;
    if (abort_at >= 1 && abort_at < end_i) end_i = abort_at;
    if (ready_at >= 1 && ready_at <= end_i) begin
      end_i = ready_at;
      e_err = slverr;
      e_rdata = e_wr ? '0 : rd_val;
    end
    exp_q.push_back({who, e_err, e_rdata});

    req0 = r0; req1 = r1; wr0 = w0; wr1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    @(posedge PCLK); @(negedge PCLK);
    check_val({tag, "_req_transfer"}, 64'(transfer), 64'(1));
    check_val({tag, "_req_gnt"}, 64'({gnt1, gnt0}), 64'(who ? 2'b10 : 2'b01));
    check_val({tag, "_req_rw"}, 64'(read_write), 64'(e_wr));
    check_val({tag, "_req_wpaddr"}, 64'(write_paddr), 64'(e_addr));
    check_val({tag, "_req_rpaddr"}, 64'(read_paddr), 64'(e_addr));
    check_val({tag, "_req_wdata"}, 64'(write_data), 64'(e_wdata));
    check_val({tag, "_req_done"}, 64'({done1, done0}), 64'(0));
    // requests change after the grant; the transaction must not notice
    req0 = 1'($urandom_range(0, 1)); req1 = 1'($urandom_range(0, 1));
    wr0 = 1'($urandom_range(0, 1)); wr1 = 1'($urandom_range(0, 1));
    addr0 = rnd_addr(); addr1 = rnd_addr(); wdata0 = $urandom; wdata1 = $urandom;
    slave_idle();
    @(posedge PCLK);
    for (int i = 0; i <= end_i; i++) begin
      @(negedge PCLK);
      check_val({tag, "_wait_transfer"}, 64'(transfer), 64'(0));
      check_val({tag, "_wait_done"}, 64'({done1, done0}), 64'(0));
      check_val({tag, "_wait_gnt"}, 64'({gnt1, gnt0}), 64'(who ? 2'b10 : 2'b01));
      check_val({tag, "_wait_wdata"}, 64'(write_data), 64'(e_wdata));
      check_val({tag, "_wait_paddr"}, 64'(write_paddr), 64'(e_addr));
      drive_slave(i, ready_at, abort_at, slverr, rd_val);
      @(posedge PCLK);
    end
    @(negedge PCLK);
    rec = exp_q.pop_front();
    check_val({tag, "_resp_done"}, 64'({done1, done0}), 64'(rec[WIDTH+1] ? 2'b10 : 2'b01));
    check_val({tag, "_resp_err"}, 64'(err), 64'(rec[WIDTH]));
    check_val({tag, "_resp_rdata"}, 64'(rdata), 64'(rec[WIDTH-1:0]));
    check_val({tag, "_resp_gnt"}, 64'({gnt1, gnt0}), 64'(who ? 2'b10 : 2'b01));
    check_val({tag, "_resp_rw"}, 64'(read_write), 64'(e_wr));
    check_val({tag, "_resp_transfer"}, 64'(transfer), 64'(0));
    slave_idle();
    req0 = 1'b0; req1 = 1'b0;
    m_last = who;
    @(posedge PCLK); @(negedge PCLK);
    check_idle({tag, "_arb"});
  endtask

  initial begin
    logic r0, r1, slv;
    int kind, rdy, abt;
    PRESETn = 1'b0;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    slave_idle();
    m_last = 1'b1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    check_idle("reset");
    PRESETn = 1'b1;
    repeat (3) begin
      @(posedge PCLK); @(negedge PCLK);
      check_idle("idle");
    end

    // simultaneous requests after reset: order 0,1,0,1
    for (int k = 0; k < 4; k++)
      run_txn(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(),
              $urandom, $urandom, $urandom, 1, -1, 0, "tie");

    // single read, zero-wait slave
    run_txn(1, 0, 0, 0, 33'h1_0000_0010, rnd_addr(), $urandom, $urandom,
            32'hCAFEF00D, 1, -1, 0, "single_read");

    // write with three low-PREADY access cycles
    run_txn(0, 1, 0, 1, rnd_addr(), 33'h0_0000_0004, $urandom, 32'h12345678,
            $urandom, 4, -1, 0, "wait_write");

    // timeout, then a normal transaction
    run_txn(1, 0, 0, 0, rnd_addr(), rnd_addr(), $urandom, $urandom, $urandom, -1, -1, 0, "timeout");
    run_txn(1, 1, 0, 0, rnd_addr(), rnd_addr(), $urandom, $urandom, $urandom, 2, -1, 0, "after_to");

    // completion in the last WAIT cycle beats timeout
    run_txn(0, 1, 0, 0, rnd_addr(), rnd_addr(), $urandom, $urandom, $urandom,
            TIMEOUT - 1, -1, 0, "to_tie");

    // slave error with PREADY, and abort without PREADY
    run_txn(1, 0, 0, 0, rnd_addr(), rnd_addr(), $urandom, $urandom, $urandom, 2, -1, 1, "slverr");
    run_txn(0, 1, 0, 0, rnd_addr(), rnd_addr(), $urandom, $urandom, $urandom, -1, 3, 0, "abort");

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      kind = $urandom_range(0, 7);
      rdy = -1; abt = -1; slv = 1'b0;
      if (kind <= 3) rdy = $urandom_range(1, TIMEOUT - 1);
      else if (kind == 4) begin rdy = $urandom_range(1, 6); slv = 1'b1; end
      else if (kind <= 6) abt = $urandom_range(1, 10);
      run_txn(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(),
              $urandom, $urandom, $urandom, rdy, abt, slv, "rand");
    end

    // reset in the middle of WAIT
    req0 = 1'b1; req1 = 1'b0; wr0 = 1'b0; addr0 = rnd_addr(); wdata0 = $urandom;
    @(posedge PCLK); @(negedge PCLK);
    check_val("mid_rst_req_gnt", 64'({gnt1, gnt0}), 64'(2'b01));
    req0 = 1'b0; req1 = 1'b1; wr1 = 1'b1; addr1 = rnd_addr();
    slave_idle();
    @(posedge PCLK); @(negedge PCLK);
    drive_slave(0, -1, -1, 0, '0);
    @(posedge PCLK); @(negedge PCLK);
    drive_slave(1, -1, -1, 0, '0);
    #2 PRESETn = 1'b0;
    #1 check_idle("mid_rst_async");
    repeat (2) begin
      @(posedge PCLK); @(negedge PCLK);
      check_idle("mid_rst_hold");
    end
    slave_idle();
    PRESETn = 1'b1;
    m_last = 1'b1;
    exp_q.delete();
    run_txn(0, 1, 0, 0, rnd_addr(), rnd_addr(), $urandom, $urandom, $urandom, 1, -1, 0, "post_rst");
    run_txn(1, 1, 0, 1, rnd_addr(), rnd_addr(), $urandom, $urandom, $urandom, 3, -1, 0, "post_rst_tie");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
